// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM encoding and
// elaboration-time sizing helpers.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // N_DIGITS = WIDTH / DIGIT; evaluated per instance since packages are not parameterised
  function automatic int n_digits(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// Combinational DIGIT-bit ripple of full-subtract cells, LSB first.
module digit_subtractor #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bw_in,
  output logic [DIGIT-1:0] d,
  output logic             bw_out
);

  always_comb begin
    logic bw;
    bw = bw_in;
    d  = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      d[i] = a[i] ^ b[i] ^ bw;
      bw   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
    end
    bw_out = bw;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: diff = a - b - borrow_in over
// WIDTH/DIGIT cycles, with ready/valid handshakes on both sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int N  = n_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [WIDTH-1:0] a_next, b_next, res_next;
  logic             bw;
  logic [CW-1:0]    cnt;
  logic             a_msb, b_msb;
  logic [DIGIT-1:0] slice_d;
  logic             slice_bw;
  logic             last;

  assign last      = (cnt == CW'(N - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .a      (a_sh[DIGIT-1:0]),
    .b      (b_sh[DIGIT-1:0]),
    .bw_in  (bw),
    .d      (slice_d),
    .bw_out (slice_bw)
  );

  // With a single digit the whole word goes through the chain at once, so no shifting.
  if (DIGIT == WIDTH) begin : g_full
    assign a_next   = '0;
    assign b_next   = '0;
    assign res_next = slice_d;
  end else begin : g_shift
    assign a_next   = {{DIGIT{1'b0}}, a_sh[WIDTH-1:DIGIT]};
    assign b_next   = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
    assign res_next = {slice_d, res_sh[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh   <= a;
          b_sh   <= b;
          bw     <= borrow_in;
          cnt    <= '0;
          a_msb  <= a[WIDTH-1];
          b_msb  <= b[WIDTH-1];
          res_sh <= '0;
        end
        RUN: begin
          a_sh   <= a_next;
          b_sh   <= b_next;
          res_sh <= res_next;
          bw     <= slice_bw;
          cnt    <= last ? '0 : cnt + CW'(1);
          if (last) begin
            diff       <= res_next;
            borrow_out <= slice_bw;
            overflow   <= (a_msb ^ b_msb) & (res_next[WIDTH-1] ^ a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
